gray_code_counter: RTL and testbench



---
 rtl/gray_code_counter.sv | 75 +++++++
 tb/tb_gray_code_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// -----------------------------------------------------------------------------
// gray_code_counter
//
// Free-running, parameterised Gray-code counter. A binary register holds the
// count. The Gray-coded output is held in its own register, loaded on the same
// edge from the next binary value. As a result, out is never a combinational
// decode. It is glitch-free for asynchronous samplers and clock-domain
// crossings, and exactly one bit of out changes per enabled step, including at
// wrap-around.
//
// Parameters
//   width  counter/output width in bits, legal range 2..32 (default 8)
//
// Ports
//   clk    input         rising-edge clock
//   reset  input         asynchronous, active-low reset; clears everything
//   en     input         count enable, sampled on the rising edge of clk
//   clr    input         synchronous clear, has priority over en
//   out    output [w-1:0] registered Gray-code count
//   bin    output [w-1:0] registered binary equivalent of out
//   wrap   output        registered; one-cycle pulse when the count wraps to 0
// -----------------------------------------------------------------------------
module gray_code_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [width-1:0] out,
    output logic [width-1:0] bin,
    output logic             wrap
);

    logic [width-1:0] b_q;
    logic [width-1:0] b_next;
    logic [width-1:0] gray_next;
    logic             wrap_next;

    // Next-state selection: clear beats enable, and enable beats hold.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        b_next    = b_q;
        wrap_next = 1'b0;
        if (clr) begin
            b_next = '0;
        end else if (en) begin
            b_next    = b_q + 1'b1;
            // The terminal count is about to roll over to zero.
            wrap_next = (b_q == {width{1'b1}});
        end
    end

    // Gray-encode the next value so out is loaded from a register.
    // It is never decoded from b_q after the edge.
    assign gray_next = b_next ^ (b_next >> 1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q  <= '0;
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            b_q  <= b_next;
            out  <= gray_next;
            wrap <= wrap_next;
        end
    end

    assign bin = b_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_code_counter
//
// Directed bench for gray_code_counter. It instantiates a width=8 and a width=3
// counter. A reference model pushes the expected out/bin/wrap for each edge to a
// scoreboard queue. After the edge the entry is popped and compared with the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_gray_code_counter;

    typedef struct {
        logic [31:0] o;
        logic [31:0] b;
        logic        w;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset8, en8, clr8;
    logic [7:0] out8, bin8;
    logic       wrap8;
    logic       reset3, en3, clr3;
    logic [2:0] out3, bin3;
    logic       wrap3;

    int checks = 0;
    int errors = 0;

    exp_t sb8[$];
    exp_t sb3[$];

    int unsigned m8 = 0;
    int unsigned m3 = 0;

    always #5 clk = ~clk;

    gray_code_counter #(.width(8)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .clr(clr8),
        .out(out8), .bin(bin8), .wrap(wrap8)
    );

    gray_code_counter #(.width(3)) dut3 (
        .clk(clk), .reset(reset3), .en(en3), .clr(clr3),
        .out(out3), .bin(bin3), .wrap(wrap3)
    );

    function automatic logic [31:0] gray(input int unsigned v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model the width=8 counter for one edge and push the expectation.
    // Then take the edge and compare against the popped entry.
    task automatic tick8(input logic e, input logic c, input string tag);
        logic w;
        exp_t x;
        en8  = e;
        clr8 = c;
        w    = 1'b0;
        if (c) begin
            m8 = 0;
        end else if (e) begin
            w  = (m8 == 255);
            m8 = (m8 + 1) % 256;
        end
        sb8.push_back('{o: gray(m8), b: m8, w: w});
        @(posedge clk);
        #1;
        x = sb8.pop_front();
        check({tag, "_out"},  {24'd0, out8}, x.o);
        check({tag, "_bin"},  {24'd0, bin8}, x.b);
        check({tag, "_wrap"}, {31'd0, wrap8}, {31'd0, x.w});
    endtask

    task automatic tick3(input string tag);
        logic w;
        exp_t x;
        w  = (m3 == 7);
        m3 = (m3 + 1) % 8;
        sb3.push_back('{o: gray(m3), b: m3, w: w});
        @(posedge clk);
        #1;
        x = sb3.pop_front();
        check({tag, "_out"},  {29'd0, out3}, x.o);
        check({tag, "_bin"},  {29'd0, bin3}, x.b);
        check({tag, "_wrap"}, {31'd0, wrap3}, {31'd0, x.w});
    endtask

    initial begin
        logic [7:0] prev;
        logic       seen [256];
        int         nseen;
        int         nwrap;
        logic [2:0] seq3 [8];

        seq3 = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        // Assert reset with no clock edge in between and check the cleared state.
        reset8 = 1'b1; en8 = 1'b1; clr8 = 1'b0;
        reset3 = 1'b1; en3 = 1'b1; clr3 = 1'b0;
        #2;
        reset8 = 1'b0;
        reset3 = 1'b0;
        #1;
        check("async_reset_out",  {24'd0, out8}, 32'd0);
        check("async_reset_bin",  {24'd0, bin8}, 32'd0);
        check("async_reset_wrap", {31'd0, wrap8}, 32'd0);
        check("async_reset3_out", {29'd0, out3}, 32'd0);

        // Hold reset across edges with en and clr toggling.
        repeat (3) @(posedge clk);
        clr8 = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold_out", {24'd0, out8}, 32'd0);
        check("reset_hold_bin", {24'd0, bin8}, 32'd0);

        // Release reset between edges, then free-run.
        @(negedge clk);
        reset8 = 1'b1;
        m8     = 0;
        tick8(1'b1, 1'b0, "run1"); check("run1_const", {24'd0, out8}, 32'h01);
        tick8(1'b1, 1'b0, "run2"); check("run2_const", {24'd0, out8}, 32'h03);
        tick8(1'b1, 1'b0, "run3"); check("run3_const", {24'd0, out8}, 32'h02);
        tick8(1'b1, 1'b0, "run4"); check("run4_const", {24'd0, out8}, 32'h06);
        tick8(1'b1, 1'b0, "run5"); check("run5_const", {24'd0, out8}, 32'h07);
        check("run5_bin_const", {24'd0, bin8}, 32'd5);

        // At bin=5, clear with en=1: clear has priority.
        tick8(1'b1, 1'b1, "clr");
        check("clr_out_const", {24'd0, out8}, 32'h00);
        check("clr_bin_const", {24'd0, bin8}, 32'd0);
        tick8(1'b1, 1'b0, "after_clr");
        check("after_clr_const", {24'd0, out8}, 32'h01);

        // Count to bin=3, then gate the enable for 4 edges.
        tick8(1'b1, 1'b0, "to2");
        tick8(1'b1, 1'b0, "to3");
        check("to3_const", {24'd0, out8}, 32'h02);
        for (int i = 0; i < 4; i++) begin
            tick8(1'b0, 1'b0, "hold");
            check("hold_const", {24'd0, out8}, 32'h02);
        end
        tick8(1'b1, 1'b0, "resume");
        check("resume_const", {24'd0, out8}, 32'h06);

        // Full period: single-bit steps, every code once, and one wrap pulse.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        nwrap = 0;
        for (int i = 0; i < 256; i++) begin
            prev = out8;
            tick8(1'b1, 1'b0, "sweep");
            check("sweep_hamming", $countones(prev ^ out8), 32'd1);
            seen[out8] = 1'b1;
            if (wrap8) nwrap++;
            if (prev == 8'h80) begin
                check("sweep_wrap_out",  {24'd0, out8}, 32'h00);
                check("sweep_wrap_flag", {31'd0, wrap8}, 32'd1);
            end
        end
        nseen = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) nseen++;
        check("sweep_all_codes", nseen, 32'd256);
        check("sweep_wrap_count", nwrap, 32'd1);

        // Count to bin=100, then pulse the reset between edges.
        while (m8 != 100) tick8(1'b1, 1'b0, "to100");
        check("at100_bin", {24'd0, bin8}, 32'd100);
        @(negedge clk);
        reset8 = 1'b0;
        m8     = 0;
        #1;
        check("midreset_out",  {24'd0, out8}, 32'd0);
        check("midreset_bin",  {24'd0, bin8}, 32'd0);
        check("midreset_wrap", {31'd0, wrap8}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midreset_hold_out", {24'd0, out8}, 32'd0);
        @(negedge clk);
        reset8 = 1'b1;
        tick8(1'b1, 1'b0, "post_reset");
        check("post_reset_const", {24'd0, out8}, 32'h01);

        // A clear at the terminal count suppresses the wrap pulse.
        while (m8 != 255) tick8(1'b1, 1'b0, "to255");
        check("at255_out", {24'd0, out8}, 32'h80);
        tick8(1'b1, 1'b1, "clr_terminal");
        check("clr_terminal_wrap", {31'd0, wrap8}, 32'd0);

        // Hold at the terminal count: with en=0 there is no wrap.
        while (m8 != 255) tick8(1'b1, 1'b0, "to255b");
        tick8(1'b0, 1'b0, "hold_terminal");
        check("hold_terminal_wrap", {31'd0, wrap8}, 32'd0);

        // width=3: the exact sequence and one wrap per 8 enabled edges.
        @(negedge clk);
        reset3 = 1'b1;
        m3     = 0;
        nwrap  = 0;
        for (int i = 1; i <= 16; i++) begin
            tick3("w3");
            check("w3_seq", {29'd0, out3}, {29'd0, seq3[i % 8]});
            if (wrap3) nwrap++;
        end
        check("w3_wrap_count", nwrap, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
